axi_injector_scheduler: RTL and testbench
=========================================

# axi_injector_scheduler

Command scheduler for the AXI injector data port. It arbitrates round-robin between a write-command queue and a read-command queue, fed by the APB register file, and issues each command as one AXI burst on AW or AR. Write bursts are also handed as descriptors to the W-beat generator. The block caps outstanding transactions per direction, retires B/R responses, and keeps completion and error counters for APB status readback.

## Interface
- ID_WIDTH, 24, AXI ID width
- MAX_OUTSTANDING, 8, max in-flight transactions per direction (≥1)
- COUNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived)
---
- aclk  in  1  clock, single domain; reset is asynchronous and active-low
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  allow command acceptance
- wcmd_valid / wcmd_ready  in / out  1  write-command handshake
- wcmd_addr, wcmd_len, wcmd_size  in  32, 8, 3  write-burst descriptor
- rcmd_valid / rcmd_ready  in / out  1  read-command handshake
- rcmd_addr, rcmd_len, rcmd_size  in  32, 8, 3  read-burst descriptor
- awid, awaddr, awlen, awsize, awburst  out  ID_WIDTH, 32, 8, 3, 2  AW payload
- awvalid / awready  out / in  1  AW handshake
- wburst_valid / wburst_ready  out / in  1  descriptor to W generator
- wburst_len  out  8  beats-1 of the write burst
- bid, bresp  in  ID_WIDTH, 2 ; bvalid / bready  in / out  1  B channel
- arid, araddr, arlen, arsize, arburst  out  ID_WIDTH, 32, 8, 3, 2  AR payload
- arvalid / arready  out / in  1  AR handshake
- rid, rresp, rlast  in  ID_WIDTH, 2, 1 ; rvalid / rready  in / out  1  R channel
- write_outstanding, read_outstanding  out  COUNT_WIDTH  in-flight counts
- write_done_count, read_done_count  out  32  completed transactions, wrapping
- error_count  out  16  error responses, saturating at 0xFFFF
- idle  out  1  IDLE state and both outstanding counts zero

## Operation
- FSM states: IDLE, ISSUE_WRITE, ISSUE_READ.
- In IDLE with enable=1:
  - Write is eligible when wcmd_valid and write_outstanding < MAX_OUTSTANDING.
  - Read is eligible when rcmd_valid and read_outstanding < MAX_OUTSTANDING.
  - The grant goes to the single eligible side. If both are eligible, the side not granted last wins; the first grant after reset goes to write.
- wcmd_ready / rcmd_ready are high only in IDLE, for the granted side. A handshake latches the payload and moves to ISSUE_WRITE or ISSUE_READ.
- ISSUE_WRITE:
  - awvalid and wburst_valid assert together and each holds until its own handshake.
  - Return to IDLE once both handshakes have occurred, in any order.
- ISSUE_READ: arvalid holds until arready, then return to IDLE.
- AW/AR fields:
  - awburst = arburst = INCR (2'b01); len and size pass through.
  - IDs come from per-direction counters that increment per issued burst and wrap modulo 2^ID_WIDTH.
- bready = rready = 1 always; responses are not matched by ID.
- Outstanding counters:
  - write_outstanding increments on the AW handshake and decrements on the B handshake. Same cycle: no change.
  - read_outstanding increments on the AR handshake and decrements on an R handshake with rlast. Same cycle: no change.
  - A retiring response when the count is 0 leaves it at 0 and increments error_count.
- Done counters increment on the B handshake / on the R handshake with rlast.
- error_count increments on a B handshake with bresp≠OKAY, and on every R beat with rresp≠OKAY. At most +1 per direction per cycle, so +2 when both occur in the same cycle; saturates.
- Deasserting enable blocks new grants only; an issue in progress completes.

## Timing
- Reset values:
  - All valids and cmd readies 0; AW/AR payloads, IDs and all counters 0; wburst_len 0.
  - bready = rready = 1; idle = 1; FSM in IDLE; round-robin pointer favours write.
- Latency: command handshake at cycle N gives awvalid/arvalid/wburst_valid high at N+1 (registered).
- Throughput: the next cmd_ready is high no earlier than the cycle after the last issue handshake, so at most one command every 2 cycles.
- Valids never drop before their handshake; payload is stable while valid.
- Asynchronous reset mid-burst abandons the issue and clears all counts; the interconnect is reset in the same domain.

## Structure
- Package axi_injector_pkg:
  - axi_burst_t (FIXED, INCR, WRAP)
  - axi_resp_t (OKAY, EXOKAY, SLVERR, DECERR)
  - scheduler_state_t
  - AXI_ADDR_WIDTH = 32, AXI_LEN_WIDTH = 8
- Sub-module axi_injector_arbiter: 2-requester round-robin with last-grant register, update on grant handshake.

## Test plan
- Single write: addr=0x1000, len=3, size=5, awready immediate → awvalid at N+1, awid=0, awburst=01, wburst_len=3; B OKAY → write_done_count=1, idle=1.
- Both queues always valid → grants alternate W,R,W,R; awid and arid each run 0,1,2.
- MAX_OUTSTANDING=8, no B responses → 8 writes issue, wcmd_ready stays 0; one B → the 9th is accepted.
- Issue and retire in the same cycle: AW handshake and B handshake together → write_outstanding unchanged. Unsolicited B at count 0 → count stays 0, error_count=1.
- R burst len=3 with rresp SLVERR on beats 1 and 2 → error_count=2, read_done_count=1 at rlast. Forced errors → error_count holds at 0xFFFF.
- Assert aresetn low during ISSUE_WRITE with awready held 0 → awvalid and wburst_valid drop immediately; all counters 0, idle=1.

Source files
------------

// File: rtl/axi_injector_pkg.sv
// Shared AXI encodings, scheduler states and the latched command descriptor.
package axi_injector_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    ISSUE_WRITE = 2'b01,
    ISSUE_READ  = 2'b10
  } scheduler_state_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [2:0]                size;
  } cmd_t;

endpackage

// File: rtl/axi_injector_arbiter.sv
// Two-requester round-robin (bit 0 = write, bit 1 = read), combinational grant, no added latency.
// The last-grant pointer moves only on an accepted grant, so a requester that stalls keeps its turn.
module axi_injector_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_wr_q, last_wr_d;

  always_comb begin
    gnt_o     = 2'b00;
    last_wr_d = last_wr_q;
    if (req_i[0] && (!req_i[1] || !last_wr_q)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
    if (accept_i) begin
      last_wr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/axi_injector_scheduler.sv
// Round-robin write/read command scheduler issuing one AXI burst per command; issue valids are registered (cmd hs at N -> valid at N+1).
// Command ready only in IDLE for the granted side and below the per-direction outstanding cap; valids hold until their handshake.
module axi_injector_scheduler
  import axi_injector_pkg::*;
#(
  parameter int ID_WIDTH        = 24,
  parameter int MAX_OUTSTANDING = 8,
  parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   enable_i,
  input  logic                   wcmd_valid_i,
  output logic                   wcmd_ready_o,
  input  logic [31:0]            wcmd_addr_i,
  input  logic [7:0]             wcmd_len_i,
  input  logic [2:0]             wcmd_size_i,
  input  logic                   rcmd_valid_i,
  output logic                   rcmd_ready_o,
  input  logic [31:0]            rcmd_addr_i,
  input  logic [7:0]             rcmd_len_i,
  input  logic [2:0]             rcmd_size_i,
  output logic [ID_WIDTH-1:0]    awid_o,
  output logic [31:0]            awaddr_o,
  output logic [7:0]             awlen_o,
  output logic [2:0]             awsize_o,
  output logic [1:0]             awburst_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic                   wburst_valid_o,
  input  logic                   wburst_ready_i,
  output logic [7:0]             wburst_len_o,
  input  logic [ID_WIDTH-1:0]    bid_i,
  input  logic [1:0]             bresp_i,
  input  logic                   bvalid_i,
  output logic                   bready_o,
  output logic [ID_WIDTH-1:0]    arid_o,
  output logic [31:0]            araddr_o,
  output logic [7:0]             arlen_o,
  output logic [2:0]             arsize_o,
  output logic [1:0]             arburst_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  input  logic [ID_WIDTH-1:0]    rid_i,
  input  logic [1:0]             rresp_i,
  input  logic                   rlast_i,
  input  logic                   rvalid_i,
  output logic                   rready_o,
  output logic [COUNT_WIDTH-1:0] write_outstanding_o,
  output logic [COUNT_WIDTH-1:0] read_outstanding_o,
  output logic [31:0]            write_done_count_o,
  output logic [31:0]            read_done_count_o,
  output logic [15:0]            error_count_o,
  output logic                   idle_o
);

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OUTSTANDING);

  scheduler_state_t       state_q, state_d;
  cmd_t                   aw_q, aw_d, ar_q, ar_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]    awid_q, awid_d, arid_q, arid_d;
  logic [COUNT_WIDTH-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [31:0]            wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic [15:0]            err_q, err_d;
  logic [16:0]            err_sum;
  logic [1:0]             req, gnt;
  logic                   wcmd_hs, rcmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, rlast_hs;
  logic                   wr_under, rd_under, w_err, r_err;
  logic                   unused_ids;

  // IDs are not matched; responses retire in arrival order.
  assign unused_ids = ^{bid_i, rid_i};

  assign req[0] = (state_q == IDLE) && enable_i && wcmd_valid_i && (wr_out_q < MAX_CNT);
  assign req[1] = (state_q == IDLE) && enable_i && rcmd_valid_i && (rd_out_q < MAX_CNT);

  axi_injector_arbiter u_arb (
    .clk_i    (aclk_i),
    .rst_ni   (aresetn_i),
    .req_i    (req),
    .accept_i (wcmd_hs || rcmd_hs),
    .gnt_o    (gnt)
  );

  // Readies are combinational from the grant; gate with reset so none shows while held in reset.
  assign wcmd_ready_o = aresetn_i && gnt[0];
  assign rcmd_ready_o = aresetn_i && gnt[1];

  assign wcmd_hs  = wcmd_valid_i && wcmd_ready_o;
  assign rcmd_hs  = rcmd_valid_i && rcmd_ready_o;
  assign aw_hs    = awvalid_q && awready_i;
  assign w_hs     = wvalid_q && wburst_ready_i;
  assign ar_hs    = arvalid_q && arready_i;
  assign b_hs     = bvalid_i;
  assign r_hs     = rvalid_i;
  assign rlast_hs = rvalid_i && rlast_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wcmd_hs)      state_d = ISSUE_WRITE;
        else if (rcmd_hs) state_d = ISSUE_READ;
      end
      ISSUE_WRITE: begin
        if ((!awvalid_q || awready_i) && (!wvalid_q || wburst_ready_i)) state_d = IDLE;
      end
      ISSUE_READ: begin
        if (ar_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_d      = aw_q;
    ar_d      = ar_q;
    awvalid_d = awvalid_q && !aw_hs;
    wvalid_d  = wvalid_q && !w_hs;
    arvalid_d = arvalid_q && !ar_hs;
    if (wcmd_hs) begin
      aw_d      = {wcmd_addr_i, wcmd_len_i, wcmd_size_i};
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
    if (rcmd_hs) begin
      ar_d      = {rcmd_addr_i, rcmd_len_i, rcmd_size_i};
      arvalid_d = 1'b1;
    end
    awid_d = aw_hs ? awid_q + ID_WIDTH'(1) : awid_q;
    arid_d = ar_hs ? arid_q + ID_WIDTH'(1) : arid_q;

    wr_out_d = wr_out_q;
    wr_under = 1'b0;
    if (aw_hs && !b_hs) begin
      wr_out_d = wr_out_q + COUNT_WIDTH'(1);
    end else if (b_hs && !aw_hs) begin
      if (wr_out_q == '0) wr_under = 1'b1;
      else                wr_out_d = wr_out_q - COUNT_WIDTH'(1);
    end

    rd_out_d = rd_out_q;
    rd_under = 1'b0;
    if (ar_hs && !rlast_hs) begin
      rd_out_d = rd_out_q + COUNT_WIDTH'(1);
    end else if (rlast_hs && !ar_hs) begin
      if (rd_out_q == '0) rd_under = 1'b1;
      else                rd_out_d = rd_out_q - COUNT_WIDTH'(1);
    end

    wr_done_d = b_hs     ? wr_done_q + 32'd1 : wr_done_q;
    rd_done_d = rlast_hs ? rd_done_q + 32'd1 : rd_done_q;

    // At most one error per direction per cycle; saturate at all-ones.
    w_err   = b_hs && ((axi_resp_t'(bresp_i) != OKAY) || wr_under);
    r_err   = r_hs && ((axi_resp_t'(rresp_i) != OKAY) || rd_under);
    err_sum = {1'b0, err_q} + 17'(w_err) + 17'(r_err);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= IDLE;
      aw_q      <= '0;
      ar_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awid_q    <= '0;
      arid_q    <= '0;
      wr_out_q  <= '0;
      rd_out_q  <= '0;
      wr_done_q <= '0;
      rd_done_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_q      <= aw_d;
      ar_q      <= ar_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awid_q    <= awid_d;
      arid_q    <= arid_d;
      wr_out_q  <= wr_out_d;
      rd_out_q  <= rd_out_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      err_q     <= err_d;
    end
  end

  assign awid_o              = awid_q;
  assign awaddr_o            = aw_q.addr;
  assign awlen_o             = aw_q.len;
  assign awsize_o            = aw_q.size;
  assign awburst_o           = INCR;
  assign awvalid_o           = awvalid_q;
  assign wburst_valid_o      = wvalid_q;
  assign wburst_len_o        = aw_q.len;
  assign bready_o            = 1'b1;
  assign arid_o              = arid_q;
  assign araddr_o            = ar_q.addr;
  assign arlen_o             = ar_q.len;
  assign arsize_o            = ar_q.size;
  assign arburst_o           = INCR;
  assign arvalid_o           = arvalid_q;
  assign rready_o            = 1'b1;
  assign write_outstanding_o = wr_out_q;
  assign read_outstanding_o  = rd_out_q;
  assign write_done_count_o  = wr_done_q;
  assign read_done_count_o   = rd_done_q;
  assign error_count_o       = err_q;
  assign idle_o              = (state_q == IDLE) && (wr_out_q == '0) && (rd_out_q == '0);

endmodule

// File: tb/tb_axi_injector_scheduler.sv
// Bench for axi_injector_scheduler: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_axi_injector_scheduler;

  localparam int IDW  = 24;
  localparam int MAXO = 8;
  localparam int CW   = 4;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           enable, wcmd_valid, wcmd_ready, rcmd_valid, rcmd_ready;
  logic [31:0]    wcmd_addr, rcmd_addr, awaddr, araddr;
  logic [7:0]     wcmd_len, rcmd_len, awlen, arlen, wburst_len;
  logic [2:0]     wcmd_size, rcmd_size, awsize, arsize;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, awready, wburst_valid, wburst_ready, bvalid, bready;
  logic           arvalid, arready, rlast, rvalid, rready, idle;
  logic [CW-1:0]  write_outstanding, read_outstanding;
  logic [31:0]    write_done_count, read_done_count;
  logic [15:0]    error_count;

  int checks = 0;
  int passed = 0;

  always #5 aclk = ~aclk;

  axi_injector_scheduler #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn), .enable_i(enable),
    .wcmd_valid_i(wcmd_valid), .wcmd_ready_o(wcmd_ready),
    .wcmd_addr_i(wcmd_addr), .wcmd_len_i(wcmd_len), .wcmd_size_i(wcmd_size),
    .rcmd_valid_i(rcmd_valid), .rcmd_ready_o(rcmd_ready),
    .rcmd_addr_i(rcmd_addr), .rcmd_len_i(rcmd_len), .rcmd_size_i(rcmd_size),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awvalid_o(awvalid), .awready_i(awready),
    .wburst_valid_o(wburst_valid), .wburst_ready_i(wburst_ready), .wburst_len_o(wburst_len),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .write_outstanding_o(write_outstanding), .read_outstanding_o(read_outstanding),
    .write_done_count_o(write_done_count), .read_done_count_o(read_done_count),
    .error_count_o(error_count), .idle_o(idle)
  );

  task automatic clear_inputs();
    enable = 0; wcmd_valid = 0; wcmd_addr = 0; wcmd_len = 0; wcmd_size = 0;
    rcmd_valid = 0; rcmd_addr = 0; rcmd_len = 0; rcmd_size = 0;
    awready = 0; wburst_ready = 0; arready = 0;
    bid = 0; bresp = 0; bvalid = 0; rid = 0; rresp = 0; rlast = 0; rvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    aresetn = 0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
  endtask

  // Presents one write command with AW/W sinks ready; returns after the issue handshakes.
  task automatic push_write(input logic [31:0] a, input logic [7:0] l, output bit ok);
    ok = 0; enable = 1; awready = 1; wburst_ready = 1;
    wcmd_valid = 1; wcmd_addr = a; wcmd_len = l; wcmd_size = 3'd2;
    for (int t = 0; t < 10 && !ok; t++) begin
      #1;
      ok = wcmd_ready;
      @(negedge aclk);
    end
    wcmd_valid = 0;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    clear_inputs();
    enable = 1; wcmd_valid = 1; rcmd_valid = 1;
    aresetn = 0;
    @(negedge aclk); #1;
    checks++; if ({wcmd_ready, rcmd_ready, awvalid, wburst_valid, arvalid} !== 5'b0) $display("FAIL reset_valids got %b exp 00000", {wcmd_ready, rcmd_ready, awvalid, wburst_valid, arvalid}); else passed++;
    checks++; if ({bready, rready, idle} !== 3'b111) $display("FAIL reset_ready_idle got %b exp 111", {bready, rready, idle}); else passed++;
    checks++; if ({awid, arid, awaddr, araddr, wburst_len} !== '0) $display("FAIL reset_payload got %h exp 0", {awid, arid, awaddr, araddr, wburst_len}); else passed++;
    checks++; if ({write_outstanding, read_outstanding, write_done_count, read_done_count, error_count} !== '0) $display("FAIL reset_counters got %h exp 0", {write_outstanding, read_outstanding, write_done_count, read_done_count, error_count}); else passed++;
    clear_inputs();
    aresetn = 1;
    @(negedge aclk);
  endtask

  task automatic test_single_write();
    do_reset();
    enable = 1; wcmd_valid = 1; wcmd_addr = 32'h1000; wcmd_len = 8'd3; wcmd_size = 3'd5;
    #1;
    checks++; if (wcmd_ready !== 1'b1) $display("FAIL sw_cmd_ready got %b exp 1", wcmd_ready); else passed++;
    @(negedge aclk);
    wcmd_addr = 32'h2000; awready = 1; wburst_ready = 1;
    #1;
    checks++; if ({awvalid, wburst_valid, wcmd_ready} !== 3'b110) $display("FAIL sw_valids got %b exp 110", {awvalid, wburst_valid, wcmd_ready}); else passed++;
    checks++; if ({awaddr, awid, awburst, awlen, awsize, wburst_len} !== {32'h1000, 24'd0, 2'b01, 8'd3, 3'd5, 8'd3}) $display("FAIL sw_payload got %h/%h/%b/%h/%h/%h exp 1000/0/01/3/5/3", awaddr, awid, awburst, awlen, awsize, wburst_len); else passed++;
    wcmd_valid = 0;
    @(negedge aclk);
    awready = 0; wburst_ready = 0;
    #1;
    checks++; if ({awvalid, wburst_valid, idle} !== 3'b000 || write_outstanding !== 4'd1) $display("FAIL sw_after_issue got v%b%b idle%b wo%0d exp v00 idle0 wo1", awvalid, wburst_valid, idle, write_outstanding); else passed++;
    bvalid = 1; bresp = 2'b00;
    @(negedge aclk);
    bvalid = 0;
    #1;
    checks++; if (write_done_count !== 32'd1 || write_outstanding !== 4'd0 || idle !== 1'b1 || error_count !== 16'd0) $display("FAIL sw_retire got done%0d wo%0d idle%b err%0d exp 1 0 1 0", write_done_count, write_outstanding, idle, error_count); else passed++;
  endtask

  task automatic test_alternate();
    int got;
    logic [31:0] exp_addr;
    do_reset();
    enable = 1; wcmd_valid = 1; rcmd_valid = 1; awready = 1; wburst_ready = 1; arready = 1;
    wcmd_addr = $urandom; rcmd_addr = $urandom;
    for (int k = 0; k < 6; k++) begin
      got = -1;
      for (int t = 0; t < 4 && got < 0; t++) begin
        #1;
        if (wcmd_ready) got = 0;
        else if (rcmd_ready) got = 1;
        else @(negedge aclk);
      end
      checks++; if (got !== k % 2) $display("FAIL alt_grant k=%0d got %0d exp %0d", k, got, k % 2); else passed++;
      exp_addr = (got == 1) ? rcmd_addr : wcmd_addr;
      @(negedge aclk);
      if (got == 1) rcmd_addr = $urandom; else wcmd_addr = $urandom;
      #1;
      if (got == 1) begin
        checks++; if ({arvalid, arid, araddr} !== {1'b1, IDW'(k / 2), exp_addr}) $display("FAIL alt_ar k=%0d got v%b id%0d a%h exp v1 id%0d a%h", k, arvalid, arid, araddr, k / 2, exp_addr); else passed++;
      end else begin
        checks++; if ({awvalid, awid, awaddr} !== {1'b1, IDW'(k / 2), exp_addr}) $display("FAIL alt_aw k=%0d got v%b id%0d a%h exp v1 id%0d a%h", k, awvalid, awid, awaddr, k / 2, exp_addr); else passed++;
      end
      @(negedge aclk);
    end
    clear_inputs();
  endtask

  task automatic test_max_outstanding();
    bit ok;
    int seen;
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      push_write($urandom, 8'($urandom), ok);
      checks++; if (!ok) $display("FAIL max_push i=%0d got not-accepted exp accepted", i); else passed++;
    end
    checks++; if (write_outstanding !== 4'(MAXO)) $display("FAIL max_count got %0d exp %0d", write_outstanding, MAXO); else passed++;
    wcmd_valid = 1;
    seen = 0;
    for (int t = 0; t < 5; t++) begin
      #1; if (wcmd_ready) seen++;
      @(negedge aclk);
    end
    bvalid = 1;
    #1; if (wcmd_ready) seen++;
    checks++; if (seen !== 0) $display("FAIL max_blocked got %0d ready cycles exp 0", seen); else passed++;
    @(negedge aclk);
    bvalid = 0;
    #1;
    checks++; if (wcmd_ready !== 1'b1 || write_outstanding !== 4'(MAXO - 1)) $display("FAIL max_ninth got rdy%b wo%0d exp rdy1 wo%0d", wcmd_ready, write_outstanding, MAXO - 1); else passed++;
    @(negedge aclk);
    wcmd_valid = 0;
    @(negedge aclk);
    #1;
    checks++; if (write_outstanding !== 4'(MAXO)) $display("FAIL max_refill got %0d exp %0d", write_outstanding, MAXO); else passed++;
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    push_write(32'h40, 8'd1, ok);
    wcmd_valid = 1; wcmd_addr = 32'h80;
    #1;
    checks++; if (!ok || wcmd_ready !== 1'b1) $display("FAIL same_setup got ok%b rdy%b exp 1 1", ok, wcmd_ready); else passed++;
    @(negedge aclk);
    wcmd_valid = 0; bvalid = 1; bresp = 2'b00;
    @(negedge aclk);
    bvalid = 0;
    #1;
    checks++; if (write_outstanding !== 4'd1 || write_done_count !== 32'd1 || error_count !== 16'd0) $display("FAIL same_cycle got wo%0d done%0d err%0d exp 1 1 0", write_outstanding, write_done_count, error_count); else passed++;
    bvalid = 1;
    @(negedge aclk);
    bvalid = 0;
    #1;
    checks++; if (write_outstanding !== 4'd0 || error_count !== 16'd0) $display("FAIL same_drain got wo%0d err%0d exp 0 0", write_outstanding, error_count); else passed++;
    bvalid = 1;
    @(negedge aclk);
    bvalid = 0;
    #1;
    checks++; if (write_outstanding !== 4'd0 || error_count !== 16'd1 || write_done_count !== 32'd3) $display("FAIL unsolicited_b got wo%0d err%0d done%0d exp 0 1 3", write_outstanding, error_count, write_done_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_read_errors();
    int exp_err;
    do_reset();
    enable = 1; rcmd_valid = 1; rcmd_addr = $urandom; rcmd_len = 8'd3; rcmd_size = 3'd3; arready = 1;
    #1;
    checks++; if (rcmd_ready !== 1'b1) $display("FAIL rd_cmd_ready got %b exp 1", rcmd_ready); else passed++;
    @(negedge aclk);
    rcmd_valid = 0;
    #1;
    checks++; if ({arvalid, arid, arlen, arsize, arburst, araddr} !== {1'b1, 24'd0, 8'd3, 3'd3, 2'b01, rcmd_addr}) $display("FAIL rd_ar got v%b id%0d l%0d s%0d b%b a%h", arvalid, arid, arlen, arsize, arburst, araddr); else passed++;
    @(negedge aclk); #1;
    checks++; if (read_outstanding !== 4'd1) $display("FAIL rd_outstanding got %0d exp 1", read_outstanding); else passed++;
    exp_err = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rresp = (b == 1 || b == 2) ? 2'b10 : 2'b00; rlast = (b == 3);
      if (b == 1 || b == 2) exp_err++;
      @(negedge aclk); #1;
      checks++; if (error_count !== 16'(exp_err) || read_done_count !== ((b == 3) ? 32'd1 : 32'd0)) $display("FAIL rd_beat b=%0d got err%0d done%0d exp err%0d done%0d", b, error_count, read_done_count, exp_err, (b == 3) ? 1 : 0); else passed++;
    end
    rvalid = 0; rlast = 0;
    #1;
    checks++; if (read_outstanding !== 4'd0 || idle !== 1'b1) $display("FAIL rd_final got ro%0d idle%b exp 0 1", read_outstanding, idle); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    bvalid = 1; bresp = 2'b10; rvalid = 1; rresp = 2'b11; rlast = 0;
    repeat (32767) @(negedge aclk);
    #1;
    checks++; if (error_count !== 16'hFFFE || write_done_count !== 32'd32767) $display("FAIL sat_pre got err%h done%0d exp FFFE 32767", error_count, write_done_count); else passed++;
    @(negedge aclk); #1;
    checks++; if (error_count !== 16'hFFFF) $display("FAIL sat_hit got %h exp FFFF", error_count); else passed++;
    @(negedge aclk); #1;
    checks++; if (error_count !== 16'hFFFF || write_outstanding !== 4'd0 || read_done_count !== 32'd0) $display("FAIL sat_hold got err%h wo%0d rd%0d exp FFFF 0 0", error_count, write_outstanding, read_done_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    push_write(32'h100, 8'd0, ok);
    bvalid = 1;
    @(negedge aclk);
    bvalid = 0; awready = 0; wburst_ready = 0; wcmd_valid = 1; wcmd_addr = 32'h200;
    @(negedge aclk);
    wcmd_valid = 0;
    #1;
    checks++; if (!ok || {awvalid, wburst_valid} !== 2'b11 || write_done_count !== 32'd1) $display("FAIL rst_setup got ok%b v%b%b done%0d exp 1 11 1", ok, awvalid, wburst_valid, write_done_count); else passed++;
    @(negedge aclk);
    #2 aresetn = 0;
    #1;
    checks++; if ({awvalid, wburst_valid, idle} !== 3'b001) $display("FAIL rst_mid_valids got %b exp 001", {awvalid, wburst_valid, idle}); else passed++;
    checks++; if ({write_outstanding, write_done_count, error_count, awid} !== '0) $display("FAIL rst_mid_counts got %h exp 0", {write_outstanding, write_done_count, error_count, awid}); else passed++;
    clear_inputs();
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
  endtask

  // Randomized traffic; the model tracks the pending work per direction and derives every output from it.
  task automatic test_random();
    int mst, wid, rdid, wo, ro, wdone, rdone, errs, beat, e;
    bit last_w, aw_p, w_p, ar_p, w_el, r_el, gw, gr, awh, wh, arh;
    logic [31:0] ea_w, ea_r;
    logic [7:0]  el_w, el_r;
    logic [2:0]  es_w, es_r;
    int rq[$];
    mst = 0; wid = 0; rdid = 0; wo = 0; ro = 0; wdone = 0; rdone = 0; errs = 0; beat = 0;
    last_w = 0; aw_p = 0; w_p = 0; ar_p = 0;
    ea_w = 0; ea_r = 0; el_w = 0; el_r = 0; es_w = 0; es_r = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (!wcmd_valid && $urandom_range(0, 2) == 0) begin
        wcmd_valid = 1; wcmd_addr = $urandom; wcmd_len = 8'($urandom); wcmd_size = 3'($urandom);
      end
      if (!rcmd_valid && $urandom_range(0, 2) == 0) begin
        rcmd_valid = 1; rcmd_addr = $urandom; rcmd_len = 8'($urandom_range(0, 3)); rcmd_size = 3'($urandom);
      end
      awready = 1'($urandom_range(0, 1)); wburst_ready = 1'($urandom_range(0, 1)); arready = 1'($urandom_range(0, 1));
      bvalid = (wo > 0) && ($urandom_range(0, 3) == 0);
      bresp = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      bid = IDW'($urandom); rid = IDW'($urandom);
      if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
        rvalid = 1; rlast = (beat == rq[0]);
      end else begin
        rvalid = 0; rlast = 0;
      end
      rresp = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00;
      #1;
      w_el = (mst == 0) && enable && wcmd_valid && (wo < MAXO);
      r_el = (mst == 0) && enable && rcmd_valid && (ro < MAXO);
      gw = w_el && (!r_el || !last_w);
      gr = r_el && !gw;
      checks++; if ({wcmd_ready, rcmd_ready} !== {gw, gr}) $display("FAIL rnd_ready cyc=%0d got %b%b exp %b%b", cyc, wcmd_ready, rcmd_ready, gw, gr); else passed++;
      checks++; if ({awvalid, wburst_valid, arvalid} !== {aw_p, w_p, ar_p}) $display("FAIL rnd_valids cyc=%0d got %b exp %b", cyc, {awvalid, wburst_valid, arvalid}, {aw_p, w_p, ar_p}); else passed++;
      if (aw_p) begin
        checks++; if ({awaddr, awlen, awsize, awid, wburst_len} !== {ea_w, el_w, es_w, IDW'(wid), el_w}) $display("FAIL rnd_aw cyc=%0d got %h/%h/%h/%0d exp %h/%h/%h/%0d", cyc, awaddr, awlen, awsize, awid, ea_w, el_w, es_w, wid); else passed++;
      end
      if (ar_p) begin
        checks++; if ({araddr, arlen, arsize, arid} !== {ea_r, el_r, es_r, IDW'(rdid)}) $display("FAIL rnd_ar cyc=%0d got %h/%h/%h/%0d exp %h/%h/%h/%0d", cyc, araddr, arlen, arsize, arid, ea_r, el_r, es_r, rdid); else passed++;
      end
      checks++; if ({write_outstanding, read_outstanding} !== {4'(wo), 4'(ro)}) $display("FAIL rnd_outstanding cyc=%0d got %0d/%0d exp %0d/%0d", cyc, write_outstanding, read_outstanding, wo, ro); else passed++;
      checks++; if ({write_done_count, read_done_count, error_count} !== {32'(wdone), 32'(rdone), 16'(errs)}) $display("FAIL rnd_counters cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc, write_done_count, read_done_count, error_count, wdone, rdone, errs); else passed++;
      checks++; if (idle !== (mst == 0 && wo == 0 && ro == 0)) $display("FAIL rnd_idle cyc=%0d got %b exp %b", cyc, idle, (mst == 0 && wo == 0 && ro == 0)); else passed++;
      awh = aw_p && awready; wh = w_p && wburst_ready; arh = ar_p && arready;
      e = 0;
      if (bvalid) begin
        wdone++; wo--;
        if (bresp != 2'b00) e++;
      end
      if (rvalid) begin
        if (rresp != 2'b00) e++;
        if (rlast) begin
          rdone++; ro--; beat = 0; void'(rq.pop_front());
        end else begin
          beat++;
        end
      end
      errs = (errs + e > 65535) ? 65535 : errs + e;
      if (awh) begin wo++; wid++; aw_p = 0; end
      if (wh) w_p = 0;
      if (arh) begin ro++; rdid++; ar_p = 0; rq.push_back(int'(el_r)); end
      if (mst == 1 && !aw_p && !w_p) mst = 0;
      else if (mst == 2 && !ar_p) mst = 0;
      else if (gw) begin
        mst = 1; last_w = 1; aw_p = 1; w_p = 1; ea_w = wcmd_addr; el_w = wcmd_len; es_w = wcmd_size;
      end else if (gr) begin
        mst = 2; last_w = 0; ar_p = 1; ea_r = rcmd_addr; el_r = rcmd_len; es_r = rcmd_size;
      end
      @(negedge aclk);
      if (gw) wcmd_valid = 0;
      if (gr) rcmd_valid = 0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_max_outstanding();
    test_same_cycle();
    test_read_errors();
    test_saturation();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
